// File: rtl/bus_pkg.sv
// Shared definitions for the two-master system bus arbiter.
//   state_t        : arbiter FSM states (IDLE, ACCESS, DONE)
//   cs_t           : decoded chip selects {gpu, led, ram}
//   LED_PAGE       : address page [15:12] of the LED register
//   GPU_PAGE       : address page [15:12] of the GPU register window
//   UNMAPPED_RDATA : read data returned for unmapped addresses
//   addr_decode()  : address -> chip select decode
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LED_PAGE       = 4'h9;
    localparam logic [3:0] GPU_PAGE       = 4'hF;
    localparam logic [7:0] UNMAPPED_RDATA = 8'hFF;

    typedef struct packed {
        logic gpu;
        logic led;
        logic ram;
    } cs_t;

    // RAM owns the lower half; the LED and GPU pages sit in the upper half.
    // Everything else in the upper half is unmapped (all selects low).
    function automatic cs_t addr_decode(input logic [15:0] addr);
        cs_t cs;
        cs.ram = !addr[15];
        cs.led = (addr[15:12] == LED_PAGE);
        cs.gpu = (addr[15:12] == GPU_PAGE);
        return cs;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two bus masters, the arbiter and the slaves.
//   Master side : m_req, m_write, m_lock, m_addr0/1, m_wdata0/1 (in to arbiter)
//                 m_ack, m_rdata (out of arbiter)
//   Slave side  : bus_addr, bus_wdata, bus_read, bus_write, cs_ram/led/gpu
//                 (out of arbiter), bus_rdata (in to arbiter)
//   Debug       : dbg_state, the arbiter FSM state
// Modports: slave = the arbiter itself, master = the environment driving it.
//
// Handshake: a master raises m_req[i] together with stable m_write[i],
// m_lock[i], address and write data, and holds them until m_ack[i] pulses
// for one cycle; m_rdata is valid only in that ack cycle. The arbiter drives
// bus_read/bus_write and one chip select for exactly one cycle per transfer
// and samples bus_rdata at the end of that cycle; slaves have no wait states.
interface bus_arbiter_if;
    import bus_pkg::*;

    logic [1:0]  m_req;
    logic [1:0]  m_write;
    logic [1:0]  m_lock;
    logic [15:0] m_addr0;
    logic [15:0] m_addr1;
    logic [7:0]  m_wdata0;
    logic [7:0]  m_wdata1;
    logic [1:0]  m_ack;
    logic [7:0]  m_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_read;
    logic        bus_write;
    logic [7:0]  bus_rdata;
    logic        cs_ram;
    logic        cs_led;
    logic        cs_gpu;
    state_t      dbg_state;

    modport slave (
        input  m_req, m_write, m_lock, m_addr0, m_addr1, m_wdata0, m_wdata1,
        input  bus_rdata,
        output m_ack, m_rdata, bus_addr, bus_wdata, bus_read, bus_write,
        output cs_ram, cs_led, cs_gpu, dbg_state
    );

    modport master (
        output m_req, m_write, m_lock, m_addr0, m_addr1, m_wdata0, m_wdata1,
        output bus_rdata,
        input  m_ack, m_rdata, bus_addr, bus_wdata, bus_read, bus_write,
        input  cs_ram, cs_led, cs_gpu, dbg_state
    );

endinterface

// File: rtl/arb_rr2.sv
// Combinational two-way round-robin picker.
//   req[1:0]    : request per master (0 = CPU, 1 = DMA)
//   prio        : master that wins when both request
//   force_valid : a lock is pending for force_id
//   force_id    : master that keeps the bus while its lock is honoured
//   grant       : index of the winning master (meaningful only if |req)
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       force_valid,
    input  logic       force_id,
    output logic       grant
);

    always_comb begin
        grant = 1'b0;
        if (force_valid && req[force_id]) begin
            grant = force_id;
        end else if (req == 2'b11) begin
            grant = prio;
        end else begin
            // Single requester (or none): bit 1 set means only DMA asks.
            grant = req[1];
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the 8-bit / 16-bit-address system bus.
// Picks an owner in IDLE, runs one single-cycle slave access in ACCESS and
// returns ack + read data in DONE (3 cycles per transfer minimum).
//   clk, reset : system clock, synchronous active-high reset
//   bus        : bus_arbiter_if.slave (master requests, slave strobes,
//                chip selects, read data return, FSM debug state)
//   LOCK_MAX   : locked grants allowed back to back before a forced release
// Build option: define BUS_ARB_LOCK_EN to honour m_lock; without it m_lock
// is ignored and no lock state exists.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    bus_arbiter_if.slave  bus
);

    state_t      state;
    logic        prio;
    logic        owner;
    logic        grant;
    logic [1:0]  ack_q;
    logic [7:0]  rdata_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        read_q;
    logic        write_q;
    cs_t         cs_q;

    logic        force_valid;
    logic        force_id;

    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic        sel_write;
    cs_t         sel_cs;
    logic        sel_mapped;

`ifdef BUS_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    logic             lock_valid;
    logic             lock_id;
    logic [CNT_W-1:0] lock_cnt;

    assign force_valid = lock_valid;
    assign force_id    = lock_id;
`else
    localparam int lock_max_unused = LOCK_MAX;
    logic unused_lock;

    assign unused_lock = ^bus.m_lock;
    assign force_valid = 1'b0;
    assign force_id    = 1'b0;
`endif

    arb_rr2 u_arb (
        .req         (bus.m_req),
        .prio        (prio),
        .force_valid (force_valid),
        .force_id    (force_id),
        .grant       (grant)
    );

    assign sel_addr   = grant ? bus.m_addr1  : bus.m_addr0;
    assign sel_wdata  = grant ? bus.m_wdata1 : bus.m_wdata0;
    assign sel_write  = bus.m_write[grant];
    assign sel_cs     = addr_decode(sel_addr);
    assign sel_mapped = |sel_cs;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            prio    <= 1'b0;
            owner   <= 1'b0;
            ack_q   <= 2'b00;
            rdata_q <= 8'h00;
            addr_q  <= 16'h0000;
            wdata_q <= 8'h00;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            cs_q    <= '0;
`ifdef BUS_ARB_LOCK_EN
            lock_valid <= 1'b0;
            lock_id    <= 1'b0;
            lock_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.m_req) begin
                        owner   <= grant;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        // Unmapped addresses still run the cycle, silently.
                        read_q  <= !sel_write && sel_mapped;
                        write_q <= sel_write && sel_mapped;
                        cs_q    <= sel_cs;
                        state   <= ACCESS;
`ifdef BUS_ARB_LOCK_EN
                        // A pending lock is consumed here whether or not the
                        // locked master still asks; if it dropped req the
                        // grant fell back to round-robin and the run ends.
                        if (lock_valid && bus.m_req[lock_id]) begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end else begin
                            lock_cnt <= '0;
                        end
                        lock_valid <= 1'b0;
`endif
                    end
                end
                ACCESS: begin
                    rdata_q <= (|cs_q) ? bus.bus_rdata : UNMAPPED_RDATA;
                    ack_q   <= owner ? 2'b10 : 2'b01;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                    cs_q    <= '0;
                    state   <= DONE;
                end
                DONE: begin
                    ack_q <= 2'b00;
                    state <= IDLE;
`ifdef BUS_ARB_LOCK_EN
                    if (bus.m_lock[owner] && (lock_cnt != CNT_W'(LOCK_MAX))) begin
                        lock_valid <= 1'b1;
                        lock_id    <= owner;
                    end else begin
                        prio     <= ~owner;
                        lock_cnt <= '0;
                    end
`else
                    prio <= ~owner;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m_ack     = ack_q;
    assign bus.m_rdata   = rdata_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_read  = read_q;
    assign bus.bus_write = write_q;
    assign bus.cs_ram    = cs_q.ram;
    assign bus.cs_led    = cs_q.led;
    assign bus.cs_gpu    = cs_q.gpu;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_bus_arbiter.sv
// Testbench for bus_arbiter: table of single transfers plus hand-written
// sequences for fair alternation, bus lock and reset during ACCESS.
module tb_bus_arbiter;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    bus_arbiter_if bif ();

    bus_arbiter #(.LOCK_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bif.m_req    = 2'b00;
        bif.m_write  = 2'b00;
        bif.m_lock   = 2'b00;
        bif.m_addr0  = 16'h0000;
        bif.m_addr1  = 16'h0000;
        bif.m_wdata0 = 8'h00;
        bif.m_wdata1 = 8'h00;
        bif.bus_rdata = 8'h00;
    endtask

    // ---------------- table-driven single transfers ----------------
    typedef struct {
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [7:0]  rd_in;
        logic        owner;
        logic        e_read;
        logic        e_write;
        logic [2:0]  e_cs;     // {gpu, led, ram}
        logic        chk_rd;
        logic [7:0]  e_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic apply_vec(input int i, input vec_t v);
        logic [15:0] e_addr;
        logic [7:0]  e_wdata;
        e_addr  = v.owner ? v.a1 : v.a0;
        e_wdata = v.owner ? v.d1 : v.d0;
        bif.m_req    = v.req;
        bif.m_write  = v.wr;
        bif.m_addr0  = v.a0;
        bif.m_addr1  = v.a1;
        bif.m_wdata0 = v.d0;
        bif.m_wdata1 = v.d1;
        bif.bus_rdata = v.rd_in;
        // Edge N: request sampled in IDLE; cycle N+1 is ACCESS.
        @(posedge clk); #1;
        chk($sformatf("v%0d_state_access", i), bif.dbg_state, ACCESS);
        chk($sformatf("v%0d_bus_addr", i), bif.bus_addr, e_addr);
        chk($sformatf("v%0d_bus_wdata", i), bif.bus_wdata, e_wdata);
        chk($sformatf("v%0d_bus_read", i), bif.bus_read, v.e_read);
        chk($sformatf("v%0d_bus_write", i), bif.bus_write, v.e_write);
        chk($sformatf("v%0d_cs", i), {bif.cs_gpu, bif.cs_led, bif.cs_ram}, v.e_cs);
        chk($sformatf("v%0d_no_early_ack", i), bif.m_ack, 2'b00);
        // Cycle N+2: ack, strobes already gone.
        @(posedge clk); #1;
        chk($sformatf("v%0d_ack", i), bif.m_ack, v.owner ? 2'b10 : 2'b01);
        if (v.chk_rd) chk($sformatf("v%0d_rdata", i), bif.m_rdata, v.e_rdata);
        chk($sformatf("v%0d_strobe_1cyc", i), {bif.bus_read, bif.bus_write}, 2'b00);
        chk($sformatf("v%0d_cs_off", i), {bif.cs_gpu, bif.cs_led, bif.cs_ram}, 3'b000);
        bif.m_req = 2'b00;
        @(posedge clk); #1;
        chk($sformatf("v%0d_back_idle", i), bif.dbg_state, IDLE);
        chk($sformatf("v%0d_ack_pulse", i), bif.m_ack, 2'b00);
    endtask

    // ---------------- ack collection for multi-transfer runs ----------------
    logic exp_q[$];
    int   exp_cyc_q[$];

    task automatic collect_acks(input string tag, input int n_acks, input int budget);
        int seen;
        logic e_own;
        int   e_cyc;
        seen = 0;
        for (int cyc = 1; cyc <= budget && seen < n_acks; cyc++) begin
            @(posedge clk); #1;
            if (bif.bus_read && bif.bus_write) begin
                chk($sformatf("%s_rw_both_c%0d", tag, cyc), {bif.bus_read, bif.bus_write}, 2'b00);
            end
            if (bif.m_ack != 2'b00) begin
                e_own = exp_q.pop_front();
                e_cyc = exp_cyc_q.pop_front();
                chk($sformatf("%s_ack%0d_owner", tag, seen), bif.m_ack, e_own ? 2'b10 : 2'b01);
                chk($sformatf("%s_ack%0d_cycle", tag, seen), cyc, e_cyc);
                seen++;
            end
        end
        chk($sformatf("%s_ack_count", tag), seen, n_acks);
    endtask

    // ---------------- main test ----------------
    initial begin
        drive_idle();

        //          req    wr     a0        a1        d0     d1     rd_in  own  rd   wr   cs      chk  rdata
        vecs[0] = '{2'b01, 2'b00, 16'h0010, 16'h0000, 8'h00, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 8'h5A};
        vecs[1] = '{2'b10, 2'b10, 16'h0000, 16'h9000, 8'h00, 8'hA5, 8'h00, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 8'h00};
        vecs[2] = '{2'b10, 2'b00, 16'h0000, 16'hA000, 8'h00, 8'h00, 8'h33, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 8'hFF};
        vecs[3] = '{2'b11, 2'b00, 16'hF123, 16'h0200, 8'h00, 8'h00, 8'hC3, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, 8'hC3};
        vecs[4] = '{2'b11, 2'b01, 16'h8000, 16'h7FFF, 8'h11, 8'h00, 8'h7E, 1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 8'h7E};
        vecs[5] = '{2'b01, 2'b01, 16'h9FFF, 16'h0000, 8'h3C, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 8'h00};
        vecs[6] = '{2'b10, 2'b00, 16'h0000, 16'hFFFF, 8'h00, 8'h00, 8'h81, 1'b1, 1'b1, 1'b0, 3'b100, 1'b1, 8'h81};
        vecs[7] = '{2'b01, 2'b00, 16'h7FFF, 16'h0000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 8'h00};
        vecs[8] = '{2'b01, 2'b01, 16'h8FFF, 16'h0000, 8'h77, 8'h00, 8'h42, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 8'hFF};

        // Reset values.
        do_reset();
        chk("rst_state", bif.dbg_state, IDLE);
        chk("rst_ack", bif.m_ack, 2'b00);
        chk("rst_rdata", bif.m_rdata, 8'h00);
        chk("rst_bus_addr", bif.bus_addr, 16'h0000);
        chk("rst_bus_wdata", bif.bus_wdata, 8'h00);
        chk("rst_strobes", {bif.bus_read, bif.bus_write}, 2'b00);
        chk("rst_cs", {bif.cs_gpu, bif.cs_led, bif.cs_ram}, 3'b000);

        for (int i = 0; i < 9; i++) apply_vec(i, vecs[i]);

        // Both masters request continuously from reset: strict alternation,
        // one ack every 3 cycles starting 2 cycles after the first sample.
        do_reset();
        drive_idle();
        bif.m_addr0 = 16'h0100;
        bif.m_addr1 = 16'h0200;
        bif.m_req   = 2'b11;
        exp_q     = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_cyc_q = '{2, 5, 8, 11};
        collect_acks("alt", 4, 20);
        bif.m_req = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // DMA holds lock; CPU joins one cycle after DMA's first grant.
        do_reset();
        drive_idle();
        bif.m_addr0 = 16'h0100;
        bif.m_addr1 = 16'h0300;
        bif.m_lock  = 2'b10;
        bif.m_req   = 2'b10;
        @(posedge clk); #1;
        chk("lock_first_grant", bif.bus_addr, 16'h0300);
        bif.m_req = 2'b11;
`ifdef BUS_ARB_LOCK_EN
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`else
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`endif
        exp_cyc_q = '{1, 4, 7, 10, 13, 16};
        collect_acks("lock", 6, 30);
        bif.m_req  = 2'b00;
        bif.m_lock = 2'b00;
        repeat (3) @(posedge clk);
        #1;

        // Reset during ACCESS drops the transfer and restores prio to CPU.
        do_reset();
        drive_idle();
        bif.m_addr0 = 16'h0010;
        bif.m_addr1 = 16'h1234;
        bif.m_req   = 2'b01;
        repeat (2) @(posedge clk);
        #1;
        bif.m_req = 2'b00;
        @(posedge clk); #1;          // back in IDLE, prio now points at DMA
        bif.m_req = 2'b10;
        @(posedge clk); #1;
        chk("rstacc_in_access", bif.dbg_state, ACCESS);
        chk("rstacc_dma_addr", bif.bus_addr, 16'h1234);
        reset = 1'b1;
        bif.m_req = 2'b11;
        @(posedge clk); #1;
        chk("rstacc_state_idle", bif.dbg_state, IDLE);
        chk("rstacc_strobes", {bif.bus_read, bif.bus_write}, 2'b00);
        chk("rstacc_cs", {bif.cs_gpu, bif.cs_led, bif.cs_ram}, 3'b000);
        chk("rstacc_no_ack", bif.m_ack, 2'b00);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rstacc_cpu_first", bif.bus_addr, 16'h0010);
        chk("rstacc_still_no_ack", bif.m_ack, 2'b00);
        @(posedge clk); #1;
        chk("rstacc_cpu_ack", bif.m_ack, 2'b01);
        bif.m_req = 2'b00;
        repeat (2) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
